// File: rtl/seq_pkg.sv
// Shared types and instruction field layout for the regfile sequencer.
// Optional single-step support is enabled with SEQ_SINGLE_STEP_EN.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_EXEC,
    S_WRITEBACK,
`ifdef SEQ_SINGLE_STEP_EN
    S_HALTED,
    S_STEP_WAIT
`else
    S_HALTED
`endif
  } seq_state_e;

  localparam int unsigned OPC_W       = 4;
  localparam int unsigned REG_FIELD_W = 3;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_MSB = 8;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_MSB = 5;
  localparam int unsigned RS2_LSB = 3;

  localparam logic [OPC_W-1:0] HALT_OPCODE = 4'hF;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Bus bundle between the sequencer and the instruction memory, register
// file and execution unit. master = sequencer side, slave = environment side.
interface regfile_sequencer_if #(
  parameter int DataWidth  = 16,
  parameter int IndexWidth = 3
) ();

  logic                  memReqValid;
  logic [DataWidth-1:0]  memReqAddr;
  logic                  memRspValid;
  logic [DataWidth-1:0]  memRspData;
  logic [IndexWidth-1:0] rfReadAddr1;
  logic [IndexWidth-1:0] rfReadAddr2;
  logic [IndexWidth-1:0] rfWriteAddr;
  logic                  rfWriteEnable;
  logic                  rfCountEnable;
  logic                  exStart;
  logic [3:0]            exOpcode;
  logic                  exDone;
  logic                  exWriteback;

  modport master (
    output memReqValid, memReqAddr,
    output rfReadAddr1, rfReadAddr2, rfWriteAddr, rfWriteEnable, rfCountEnable,
    output exStart, exOpcode,
    input  memRspValid, memRspData, exDone, exWriteback
  );

  modport slave (
    input  memReqValid, memReqAddr,
    input  rfReadAddr1, rfReadAddr2, rfWriteAddr, rfWriteEnable, rfCountEnable,
    input  exStart, exOpcode,
    output memRspValid, memRspData, exDone, exWriteback
  );

endinterface

// File: rtl/seq_instr_decode.sv
// Combinational instruction slicer: opcode, rd, rs1, rs2 and halt flag.
module seq_instr_decode
  import seq_pkg::*;
#(
  parameter int               DataWidth  = 16,
  parameter logic [OPC_W-1:0] HaltOpcode = HALT_OPCODE
) (
  input  logic [DataWidth-1:0]   instr,
  output logic [OPC_W-1:0]       opcode,
  output logic [REG_FIELD_W-1:0] rd,
  output logic [REG_FIELD_W-1:0] rs1,
  output logic [REG_FIELD_W-1:0] rs2,
  output logic                   halt
);

  logic unused_low_bits;

  always_comb begin
    opcode          = instr[OPC_MSB:OPC_LSB];
    rd              = instr[RD_MSB:RD_LSB];
    rs1             = instr[RS1_MSB:RS1_LSB];
    rs2             = instr[RS2_MSB:RS2_LSB];
    halt            = (instr[OPC_MSB:OPC_LSB] == HaltOpcode);
    unused_low_bits = ^instr[RS2_LSB-1:0];
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle fetch/execute controller for the register file control side.
// Define SEQ_SINGLE_STEP_EN to add the step input and STEP_WAIT state.
module regfile_sequencer
  import seq_pkg::*;
#(
  parameter int               DataWidth  = 16,
  parameter int               NumRegs    = 8,
  parameter int               IndexWidth = $clog2(NumRegs),
  parameter logic [OPC_W-1:0] HaltOpcode = HALT_OPCODE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [DataWidth-1:0] programCounter,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                 step,
`endif
  regfile_sequencer_if.master  bus,
  output logic                 retired,
  output logic                 halted
);

  seq_state_e state;
  logic [DataWidth-1:0]   ir;
  logic [DataWidth-1:0]   dec_word;
  logic [OPC_W-1:0]       dec_opcode;
  logic [REG_FIELD_W-1:0] dec_rd;
  logic [REG_FIELD_W-1:0] dec_rs1;
  logic [REG_FIELD_W-1:0] dec_rs2;
  logic                   dec_halt;

  // One decoder serves both the halt check on the incoming word (WAIT_MEM)
  // and the field outputs from the instruction register (all other states).
  always_comb begin
    dec_word = (state == S_WAIT_MEM) ? bus.memRspData : ir;
  end

  seq_instr_decode #(
    .DataWidth  (DataWidth),
    .HaltOpcode (HaltOpcode)
  ) u_decode (
    .instr  (dec_word),
    .opcode (dec_opcode),
    .rd     (dec_rd),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .halt   (dec_halt)
  );

  always_comb begin
    bus.exOpcode    = dec_opcode;
    bus.rfWriteAddr = IndexWidth'(dec_rd);
    bus.rfReadAddr1 = IndexWidth'(dec_rs1);
    bus.rfReadAddr2 = IndexWidth'(dec_rs2);
  end

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  always_comb begin
    step_rise = step & ~step_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      ir                <= '0;
      bus.memReqValid   <= 1'b0;
      bus.memReqAddr    <= '0;
      bus.rfWriteEnable <= 1'b0;
      bus.rfCountEnable <= 1'b0;
      bus.exStart       <= 1'b0;
      retired           <= 1'b0;
      halted            <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      step_q            <= 1'b0;
`endif
    end else begin
      bus.memReqValid   <= 1'b0;
      bus.rfWriteEnable <= 1'b0;
      bus.rfCountEnable <= 1'b0;
      bus.exStart       <= 1'b0;
      retired           <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      step_q            <= step;
`endif
      case (state)
        S_IDLE: begin
          if (run) begin
            state           <= S_FETCH;
            bus.memReqValid <= 1'b1;
            bus.memReqAddr  <= programCounter;
          end
        end
        S_FETCH: begin
          state <= S_WAIT_MEM;
        end
        S_WAIT_MEM: begin
          if (bus.memRspValid) begin
            ir <= bus.memRspData;
            if (dec_halt) begin
              state   <= S_HALTED;
              retired <= 1'b1;
              halted  <= 1'b1;
            end else begin
              state       <= S_EXEC;
              bus.exStart <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (bus.exDone) begin
            state             <= S_WRITEBACK;
            bus.rfWriteEnable <= bus.exWriteback;
            bus.rfCountEnable <= 1'b1;
            retired           <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (!run) begin
            state <= S_IDLE;
          end else begin
`ifdef SEQ_SINGLE_STEP_EN
            state <= S_STEP_WAIT;
`else
            state           <= S_FETCH;
            bus.memReqValid <= 1'b1;
            bus.memReqAddr  <= programCounter;
`endif
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_STEP_WAIT: begin
          if (!run) begin
            state <= S_IDLE;
          end else if (step_rise) begin
            state           <= S_FETCH;
            bus.memReqValid <= 1'b1;
            bus.memReqAddr  <= programCounter;
          end
        end
`endif
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed self-checking bench for regfile_sequencer (default or SEQ_SINGLE_STEP_EN build).
module tb_regfile_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] programCounter;
  logic        retired;
  logic        halted;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
  logic        auto_step;
`endif

  regfile_sequencer_if #(.DataWidth(16), .IndexWidth(3)) bus ();

  regfile_sequencer #(
    .DataWidth  (16),
    .NumRegs    (8),
    .HaltOpcode (4'hF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .programCounter (programCounter),
`ifdef SEQ_SINGLE_STEP_EN
    .step           (step),
`endif
    .bus            (bus),
    .retired        (retired),
    .halted         (halted)
  );

  int unsigned errors;
  int unsigned checks;
  int unsigned cyc;
  int unsigned req_cnt;
  int unsigned ret_cnt;
  int unsigned ce_cnt;
  int unsigned we_cnt;
  int unsigned exst_cnt;
  int unsigned last_lat;
  logic [15:0] pc_model;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sample registered outputs on the active edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.memReqValid)   req_cnt  = req_cnt + 1;
    if (retired)           ret_cnt  = ret_cnt + 1;
    if (bus.rfCountEnable) ce_cnt   = ce_cnt + 1;
    if (bus.rfWriteEnable) we_cnt   = we_cnt + 1;
    if (bus.exStart)       exst_cnt = exst_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fetch();
    int unsigned n;
    n = 0;
    while (!bus.memReqValid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req", {31'd0, bus.memReqValid}, 32'd1);
    check("fetch_addr", {16'd0, bus.memReqAddr}, {16'd0, pc_model});
  endtask

  task automatic do_instr(input logic [15:0] instr, input int unsigned mem_lat,
                          input int unsigned ex_lat, input logic wb,
                          input logic [15:0] wdata, input logic drop_run);
    int unsigned n;
    int unsigned t_req;
    logic [3:0] f_op;
    logic [2:0] f_rd, f_rs1, f_rs2;
    f_op  = instr[15:12];
    f_rd  = instr[11:9];
    f_rs1 = instr[8:6];
    f_rs2 = instr[5:3];
    wait_fetch();
    t_req = cyc;
    repeat (mem_lat) @(negedge clk);
    bus.memRspValid = 1'b1;
    bus.memRspData  = instr;
    @(negedge clk);
    bus.memRspValid = 1'b0;
    n = 0;
    while (!bus.exStart && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ex_start", {31'd0, bus.exStart}, 32'd1);
    check("ex_opcode", {28'd0, bus.exOpcode}, {28'd0, f_op});
    check("rs1", {29'd0, bus.rfReadAddr1}, {29'd0, f_rs1});
    check("rs2", {29'd0, bus.rfReadAddr2}, {29'd0, f_rs2});
    if (drop_run) run = 1'b0;
    if (ex_lat > 1) begin
      @(negedge clk);
      check("ex_start_once", {31'd0, bus.exStart}, 32'd0);
      repeat (ex_lat - 2) @(negedge clk);
    end
    bus.exDone      = 1'b1;
    bus.exWriteback = wb;
    @(negedge clk);
    bus.exDone      = 1'b0;
    bus.exWriteback = 1'b0;
    check("wb_we", {31'd0, bus.rfWriteEnable}, {31'd0, wb});
    check("wb_ce", {31'd0, bus.rfCountEnable}, 32'd1);
    check("wb_retired", {31'd0, retired}, 32'd1);
    check("wb_rd", {29'd0, bus.rfWriteAddr}, {29'd0, f_rd});
    check("wb_opcode", {28'd0, bus.exOpcode}, {28'd0, f_op});
    last_lat = cyc - t_req + 1;
    // Register file model: a write to the PC register overrides the increment.
    if (bus.rfWriteEnable && bus.rfWriteAddr == 3'd7) pc_model = wdata;
    else if (bus.rfCountEnable) pc_model = pc_model + 16'd1;
    programCounter = pc_model;
    @(negedge clk);
    check("retired_pulse", {31'd0, retired}, 32'd0);
    check("ce_pulse", {31'd0, bus.rfCountEnable}, 32'd0);
`ifdef SEQ_SINGLE_STEP_EN
    if (auto_step) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
`endif
  endtask

  initial begin
    int unsigned q0, r0, c0, e0, w0;
    errors = 0; checks = 0; cyc = 0;
    req_cnt = 0; ret_cnt = 0; ce_cnt = 0; we_cnt = 0; exst_cnt = 0;
    last_lat = 0;
    pc_model = 16'h0000;
    programCounter = 16'h0000;
    rst = 1'b1;
    run = 1'b1;
    bus.memRspValid = 1'b0;
    bus.memRspData  = 16'h0000;
    bus.exDone      = 1'b0;
    bus.exWriteback = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
    auto_step = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_memreq", {31'd0, bus.memReqValid}, 32'd0);
    check("rst_we", {31'd0, bus.rfWriteEnable}, 32'd0);
    check("rst_ce", {31'd0, bus.rfCountEnable}, 32'd0);
    check("rst_exstart", {31'd0, bus.exStart}, 32'd0);
    check("rst_retired", {31'd0, retired}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_opcode", {28'd0, bus.exOpcode}, 32'd0);
    check("rst_addr", {16'd0, bus.memReqAddr}, 32'd0);
    rst = 1'b0;

    // 0x1298: op=1 rd=1 rs1=2 rs2=3, 1-cycle memory, 2-cycle execute.
    do_instr(16'h1298, 1, 2, 1'b1, 16'h0000, 1'b0);
    check("lat_min", last_lat, 32'd5);
    check("i1_rs1", {29'd0, bus.rfReadAddr1}, 32'd2);
    check("i1_rs2", {29'd0, bus.rfReadAddr2}, 32'd3);
    check("i1_rd", {29'd0, bus.rfWriteAddr}, 32'd1);
    check("i1_op", {28'd0, bus.exOpcode}, 32'd1);
    check("pc_after_i1", {16'd0, pc_model}, 32'h0001);

    // Write to rd=7: write wins over the count strobe.
    do_instr(16'h2E00, 1, 1, 1'b1, 16'h0040, 1'b0);
    check("pc_write_wins", {16'd0, pc_model}, 32'h0040);
    // No writeback; fetch address proves the PC write reached the DUT.
    do_instr(16'h3000, 2, 3, 1'b0, 16'h0000, 1'b0);
    check("pc_after_i3", {16'd0, pc_model}, 32'h0041);
    // rd=0 with writeback: strobe still issued.
    do_instr(16'h4000, 1, 1, 1'b1, 16'h1234, 1'b0);
    check("pc_after_i4", {16'd0, pc_model}, 32'h0042);

    // run drops in EXEC: instruction retires, then FSM parks in IDLE.
    do_instr(16'h5252, 1, 3, 1'b1, 16'h0000, 1'b1);
    q0 = req_cnt; r0 = ret_cnt; e0 = exst_cnt; w0 = we_cnt;
    repeat (3) @(negedge clk);
    bus.exDone = 1'b1; bus.exWriteback = 1'b1; bus.memRspValid = 1'b1;
    @(negedge clk);
    bus.exDone = 1'b0; bus.exWriteback = 1'b0; bus.memRspValid = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_no_req", req_cnt - q0, 32'd0);
    check("idle_spurious_ret", ret_cnt - r0, 32'd0);
    check("idle_spurious_ex", exst_cnt - e0, 32'd0);
    check("idle_spurious_we", we_cnt - w0, 32'd0);
    run = 1'b1;
    do_instr(16'h1298, 1, 1, 1'b1, 16'h0000, 1'b0);

    // Asynchronous reset in WAIT_MEM, then a stale response.
    wait_fetch();
    @(negedge clk);
    c0 = ce_cnt; w0 = we_cnt;
    rst = 1'b1;
    run = 1'b0;
    #1;
    check("arst_opcode", {28'd0, bus.exOpcode}, 32'd0);
    check("arst_rs1", {29'd0, bus.rfReadAddr1}, 32'd0);
    check("arst_memaddr", {16'd0, bus.memReqAddr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q0 = req_cnt; e0 = exst_cnt;
    bus.memRspValid = 1'b1;
    bus.memRspData  = 16'h2E00;
    @(negedge clk);
    bus.memRspValid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_ex", exst_cnt - e0, 32'd0);
    check("abort_no_req", req_cnt - q0, 32'd0);
    check("abort_no_ce", ce_cnt - c0, 32'd0);
    check("abort_no_we", we_cnt - w0, 32'd0);
    check("abort_opcode", {28'd0, bus.exOpcode}, 32'd0);
    check("abort_halted", {31'd0, halted}, 32'd0);
    run = 1'b1;
    do_instr(16'h6148, 1, 2, 1'b0, 16'h0000, 1'b0);

`ifdef SEQ_SINGLE_STEP_EN
    auto_step = 1'b0;
    do_instr(16'h1298, 1, 1, 1'b1, 16'h0000, 1'b0);
    q0 = req_cnt; r0 = ret_cnt;
    repeat (5) @(negedge clk);
    check("step_wait_hold", req_cnt - q0, 32'd0);
    step = 1'b1; @(negedge clk); step = 1'b0;
    do_instr(16'h1298, 1, 1, 1'b1, 16'h0000, 1'b0);
    step = 1'b1; @(negedge clk); step = 1'b0;
    do_instr(16'h1298, 1, 1, 1'b1, 16'h0000, 1'b0);
    repeat (10) @(negedge clk);
    check("step_two_pulses", ret_cnt - r0, 32'd2);
    r0 = ret_cnt;
    step = 1'b1; @(negedge clk);
    do_instr(16'h1298, 1, 1, 1'b1, 16'h0000, 1'b0);
    q0 = req_cnt;
    repeat (20) @(negedge clk);
    check("step_held_one", ret_cnt - r0, 32'd1);
    check("step_held_no_req", req_cnt - q0, 32'd0);
    step = 1'b0; @(negedge clk);
    step = 1'b1; @(negedge clk);
    step = 1'b0;
    auto_step = 1'b1;
`endif

    // Halt opcode: one retire, no count strobe, no further fetches.
    wait_fetch();
    @(negedge clk);
    q0 = req_cnt; r0 = ret_cnt; c0 = ce_cnt;
    bus.memRspValid = 1'b1;
    bus.memRspData  = 16'hF000;
    @(negedge clk);
    bus.memRspValid = 1'b0;
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_retired", {31'd0, retired}, 32'd1);
    check("halt_no_ex", {31'd0, bus.exStart}, 32'd0);
    repeat (20) @(negedge clk);
    check("halt_ret_once", ret_cnt - r0, 32'd1);
    check("halt_no_req", req_cnt - q0, 32'd0);
    check("halt_no_ce", ce_cnt - c0, 32'd0);
    check("halt_sticky", {31'd0, halted}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle fetch/execute controller that drives the control side of the CPU register file: read/write addresses, write enable and PC count enable.
- Fetches an instruction from memory at the current PC, decodes register fields and hands the opcode to the execution unit.
- Issues the writeback and advances the PC once per retired instruction.
- Sits between the instruction memory port, the register file and the ALU/execution unit. Write data flows from the execution unit directly to the register file and does not pass through this block.

Parameters:
- DataWidth, 16, instruction/data/PC width
- NumRegs, 8, register count; register 0 reads zero, register NumRegs-1 is the PC
- IndexWidth, $clog2(NumRegs), register index width
- HaltOpcode, 4'hF, opcode that moves the sequencer to HALTED

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; leaves IDLE when high
- programCounter  in  DataWidth  current PC from the register file
- memReqValid  out  1  one-cycle instruction fetch request
- memReqAddr  out  DataWidth  fetch address, equal to PC latched at request
- memRspValid  in  1  fetch data valid, never in the same cycle as the request
- memRspData  in  DataWidth  instruction word
- rfReadAddr1  out  IndexWidth  = instr[8:6]
- rfReadAddr2  out  IndexWidth  = instr[5:3]
- rfWriteAddr  out  IndexWidth  = instr[11:9]
- rfWriteEnable  out  1  writeback strobe
- rfCountEnable  out  1  PC increment strobe
- exStart  out  1  one-cycle execute start pulse
- exOpcode  out  4  = instr[15:12]
- exDone  in  1  execution complete, earliest the cycle after exStart
- exWriteback  in  1  sampled with exDone; result must be written to rd
- retired  out  1  one-cycle pulse per completed instruction
- halted  out  1  high in HALTED state

Behaviour:
- States: IDLE, FETCH, WAIT_MEM, EXEC, WRITEBACK, HALTED. Reset puts the FSM in IDLE and clears every output and the instruction register to 0.
- IDLE: no outputs asserted. Go to FETCH when run=1.
- FETCH: memReqValid=1 for one cycle with memReqAddr=programCounter; PC is latched in the same cycle. Go to WAIT_MEM.
- WAIT_MEM: hold until memRspValid=1, then capture memRspData into the instruction register.
  - Opcode == HaltOpcode: go to HALTED and pulse retired. No PC increment and no write.
  - Otherwise: go to EXEC.
- EXEC:
  - exStart pulses in the first EXEC cycle only.
  - Read addresses and exOpcode are stable from EXEC entry through WRITEBACK.
  - Wait for exDone. Latch exWriteback, then go to WRITEBACK.
- WRITEBACK (one cycle):
  - rfWriteEnable = latched exWriteback.
  - rfCountEnable = 1.
  - retired = 1.
  - Next state is FETCH if run=1, else IDLE.
  - When rd == NumRegs-1 the write wins; the register file suppresses the increment. The sequencer still asserts rfCountEnable.
  - rd == 0 with writeback: strobe issued, register file discards it.
- Minimum instruction latency: 4 cycles (FETCH, WAIT_MEM ≥1, EXEC ≥1, WRITEBACK).
- HALTED is left only by reset.
- run dropping mid-instruction: the instruction completes, and the FSM stops in IDLE after WRITEBACK.
- Spurious memRspValid outside WAIT_MEM and exDone outside EXEC are ignored.
- Reset asserted in any state aborts immediately. No write or count strobe is issued for the aborted instruction.
- rfWriteEnable, rfCountEnable, exStart, memReqValid and retired are registered outputs.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- With the macro defined:
  - Adds input `step` (1 bit).
  - After WRITEBACK, the FSM enters state STEP_WAIT instead of FETCH and waits for a rising edge of step (edge detected internally) before going to FETCH.
  - The run=0 rule still routes to IDLE.
- Without the macro: no step port, no STEP_WAIT state; WRITEBACK goes directly to FETCH.

Decomposition:
- Package seq_pkg holds:
  - state enum seq_state_e;
  - instruction field bit positions (OPC_MSB/LSB, RD, RS1, RS2);
  - HALT_OPCODE default.
- One natural sub-module: seq_instr_decode, purely combinational. It slices the instruction register into opcode, rd, rs1 and rs2, and flags halt.

Test Plan:
- Reset with run=1, PC=0x0000, memory returns 0x1298 after 1 cycle, exDone after 2 cycles with exWriteback=1:
  - memReqAddr=0x0000;
  - rfReadAddr1=2, rfReadAddr2=3, rfWriteAddr=1, exOpcode=1;
  - one cycle with rfWriteEnable=1, rfCountEnable=1, retired=1;
  - total 5 cycles.
- Instruction 0x2E00 (rd=7) with exWriteback=1: rfWriteEnable and rfCountEnable both high in WRITEBACK. Bench register file model shows PC = written value, not +1.
- Instruction 0xF000: halted=1, retired pulses once, no further memReqValid for 20 cycles, rfCountEnable never asserted.
- run deasserted during EXEC: WRITEBACK completes, FSM returns to IDLE, no new memReqValid until run=1 again.
- rst asserted during WAIT_MEM, then memRspValid arrives: outputs all 0 and FSM in IDLE. Ignored response causes no exStart.
- SEQ_SINGLE_STEP_EN build: two step pulses give exactly two retired pulses. Holding step high gives only one.
